// File: rtl/mp_reg_file_sb.sv
// Multi-port register file with same-cycle write bypass and a per-register
// pending scoreboard used by decode to stall on RAW hazards.
module mp_reg_file_sb #(
    parameter int NREAD  = 4,
    parameter int NWRITE = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NISSUE = 2
) (
    input  logic                     rf_in_clk,
    input  logic                     rf_in_rstL,
    input  logic [NREAD*ADDR_W-1:0]  raddr_bus,
    output logic [NREAD*DATA_W-1:0]  rdata_bus,
    output logic [NREAD-1:0]         rbusy_bus,
    input  logic [NWRITE-1:0]        we_bus,
    input  logic [NWRITE*ADDR_W-1:0] waddr_bus,
    input  logic [NWRITE*DATA_W-1:0] wdata_bus,
    input  logic [NISSUE-1:0]        iss_valid,
    input  logic [NISSUE*ADDR_W-1:0] iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   pend_q;
    logic [NREG-1:0]   pend_d;

    logic [NWRITE-1:0] w_eff;
    logic [NREG-1:0]   wr_hit;
    logic [NREG-1:0]   iss_hit;
    logic [ADDR_W:0]   pend_sum;

    always_comb begin
        w_eff = '0;
        for (int k = 0; k < NWRITE; k++) begin
            w_eff[k] = we_bus[k] && (waddr_bus[k*ADDR_W +: ADDR_W] != '0);
        end
    end

    // Ascending lane order: a younger lane to the same address overwrites an older one.
    // NOTE: blocking assignments are correct here; always_comb models wires, and later
    // statements must see earlier ones within the same evaluation.
    always_comb begin
        regs_d = regs_q;
        wr_hit = '0;
        for (int k = 0; k < NWRITE; k++) begin
            if (w_eff[k]) begin
                regs_d[waddr_bus[k*ADDR_W +: ADDR_W]] = wdata_bus[k*DATA_W +: DATA_W];
                wr_hit[waddr_bus[k*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    // A new producer issuing this cycle outranks a writeback clearing the old one.
    always_comb begin
        iss_hit = '0;
        for (int j = 0; j < NISSUE; j++) begin
            if (iss_valid[j]) begin
                iss_hit[iss_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        iss_hit[0] = 1'b0;
        pend_d     = flush ? '0 : ((pend_q & ~wr_hit) | iss_hit);
        pend_d[0]  = 1'b0;
    end

    // NOTE: the register array is reset on purpose; software relies on every
    // architectural register reading zero after reset, so this is not storage
    // that could be left uninitialised.
    always_ff @(posedge rf_in_clk) begin
        if (rf_in_rstL) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin : read_ports
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;
        logic              byp;
        rdata_bus = '0;
        rbusy_bus = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra  = raddr_bus[i*ADDR_W +: ADDR_W];
            val = regs_q[ra];
            byp = 1'b0;
            for (int k = 0; k < NWRITE; k++) begin
                if (w_eff[k] && (waddr_bus[k*ADDR_W +: ADDR_W] == ra)) begin
                    val = wdata_bus[k*DATA_W +: DATA_W];
                    byp = 1'b1;
                end
            end
            if (!rf_in_rstL && (ra != '0)) begin
                rdata_bus[i*DATA_W +: DATA_W] = val;
                rbusy_bus[i]                  = pend_q[ra] && !byp;
            end
        end
    end

    always_comb begin
        pend_sum = '0;
        for (int r = 0; r < NREG; r++) begin
            pend_sum = pend_sum + (ADDR_W+1)'(pend_q[r]);
        end
        pend_cnt = rf_in_rstL ? '0 : pend_sum;
    end

endmodule
